mul_seq_32: RTL and testbench
=============================

Name: mul_seq_32

Overview:
- Iterative 32x32 multiply controller for the RISC-V M-extension.
- Implements MUL, MULH, MULHSU and MULHU.
- Time-shares one internal wallace_8 (8x8 -> 16-bit unsigned) instance over byte pairs of the operands and accumulates shifted partial products in a 64-bit register.
- Sits between the EX stage and the muldiv result mux, with a start/busy/done handshake.

Parameters:
- XLEN, 32, operand/result width; only 32 supported.
- NPP, 16, number of byte-pair partial products, (XLEN/8)^2.

Ports:
- clk_i  input  1  core clock, rising edge.
- reset_i  input  1  synchronous, active-high reset.
- start_i  input  1  request; sampled only in IDLE.
- op_i  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; sampled with start_i.
- rs1_i  input  32  multiplicand A; sampled with start_i.
- rs2_i  input  32  multiplier B; sampled with start_i.
- flush_i  input  1  synchronous abort from pipeline flush.
- busy_o  output  1  high from the cycle after acceptance until done_o (inclusive).
- done_o  output  1  one-cycle pulse, result_o valid.
- result_o  output  32  result; held until the next accepted start.

Behaviour:
- Reset (reset_i=1 at an edge): state IDLE, busy_o=0, done_o=0, result_o=0, accumulator=0, counter=0. Reset mid-operation aborts it; no done_o.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start_i=1 at edge:
  - Latch op.
  - sA = rs1[31] for MULH/MULHSU, else 0.
  - sB = rs2[31] for MULH only.
  - Latch |A|, |B| as 32-bit unsigned; 0x8000_0000 maps to magnitude 0x8000_0000.
  - neg = sA^sB; clear accumulator and counter; go to CALC.
- CALC: one partial product per edge.
  - k = counter[3:0]; i = k[1:0] (byte of |A|); j = k[3:2] (byte of |B|).
  - acc <= acc + (wallace_8(|A|byte i, |B|byte j) zero-extended << 8*(i+j)).
  - counter increments. After k=15 go to FIX.
- FIX: acc <= neg ? (~acc + 1) : acc, as a 64-bit two's complement; go to DONE.
- DONE: done_o=1 for exactly this cycle.
  - result_o = acc[31:0] for MUL, acc[63:32] otherwise; result_o is registered on entry to DONE.
  - Next edge returns to IDLE.
- Latency:
  - Accepting edge = edge 0. Accumulation on edges 1..16, FIX on edge 17.
  - done_o high in the cycle following edge 17, with no back-pressure.
  - Back-to-back: start_i may be asserted in the DONE cycle; it is ignored. It is accepted in the following IDLE cycle.
- start_i while busy: ignored; operands and op unchanged.
- flush_i=1 at an edge in any state: return to IDLE, busy_o=0 next cycle, no done_o.
  - result_o keeps its old value.
  - flush_i and start_i together in IDLE: flush wins; the request is not accepted.
- Arithmetic: the accumulator is 64-bit. No carry is lost because the sum of partials is at most (2^32-1)^2. Zero operands run the full sequence; no early exit.

Optional Feature:
- Macro MUL_SEQ_FAST_LOW_EN.
- Defined: for op MUL, pairs with i+j>=4 are skipped because they do not affect acc[31:0].
  - The counter visits only the 10 pairs with i+j<=3, in increasing k order.
  - CALC lasts 10 edges and done_o appears after edge 11.
  - MULH/MULHSU/MULHU are unchanged (17).
- Undefined: all ops take 16 CALC edges, done after edge 17.

Test Plan:
- MUL rs1=0x0000_0007, rs2=0x0000_0006 -> done_o pulse 17 edges after accept (11 with MUL_SEQ_FAST_LOW_EN), result_o=0x0000_002A, busy_o high throughout.
- MULH rs1=0x8000_0000, rs2=0x8000_0000 -> result_o=0x4000_0000.
- MULH rs1=0xFFFF_FFFF, rs2=0xFFFF_FFFF -> result_o=0x0000_0000. MUL with the same operands -> 0x0000_0001.
- MULHSU rs1=0xFFFF_FFFF, rs2=0xFFFF_FFFF -> result_o=0xFFFF_FFFF. MULHU with the same operands -> 0xFFFF_FFFE.
- Start MULHU 0x1234_5678 x 0x9ABC_DEF0. Pulse start_i with other operands on edge 3 (ignored). Assert flush_i on edge 5 -> busy_o=0 next cycle, no done_o, result_o unchanged. Restart same MULHU -> result_o=0x0B00_EA4E.
- Assert reset_i on edge 8 of a MULH -> all outputs 0 next cycle, no done_o. A subsequent MUL 0xFFFF_FFFE x 0x0000_0003 -> result_o=0xFFFF_FFFA.

Source files
------------

// File: rtl/mul_seq_32.sv
// Purpose : iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU), one 8x8 byte-pair product per cycle.
// Latency : done_o in the cycle after edge 17 from acceptance (edge 11 for MUL when MUL_SEQ_FAST_LOW_EN is defined).
// Backpressure: none; start_i is ignored while busy, flush_i aborts without done_o.
//
// Ports:
//   clk_i, reset_i       - core clock, synchronous active-high reset
//   start_i, op_i        - request and opcode (00 MUL, 01 MULH, 10 MULHSU, 11 MULHU), sampled in IDLE
//   rs1_i, rs2_i         - operands A and B, sampled with start_i
//   flush_i              - synchronous abort, wins over start_i
//   busy_o, done_o       - busy from cycle after accept through done; done is a one-cycle pulse
//   result_o             - registered result, held until the next operation completes
// Optional build macro: MUL_SEQ_FAST_LOW_EN (MUL skips byte pairs that cannot reach result bits [31:0]).

// 8x8 unsigned multiplier built as a carry-save tree over the eight partial-product rows.
module wallace_8 (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);
    // 3:2 compressor on 16-bit vectors; returns {carry, sum}. Carries shifted out of bit 15
    // are dropped safely because the true product fits in 16 bits.
    function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        logic [15:0] s;
        logic [15:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {c, s};
    endfunction

    logic [15:0] pp [8];
    logic [31:0] l1a, l1b, l2a, l2b, l3, l4;

    always_comb begin
        for (int r = 0; r < 8; r++) begin
            pp[r] = b_i[r] ? ({8'd0, a_i} << r) : 16'd0;
        end
    end

    // 8 rows -> 6 -> 4 -> 3 -> 2, then one carry-propagate add.
    assign l1a = csa(pp[0], pp[1], pp[2]);
    assign l1b = csa(pp[3], pp[4], pp[5]);
    assign l2a = csa(l1a[15:0], l1a[31:16], l1b[15:0]);
    assign l2b = csa(l1b[31:16], pp[6], pp[7]);
    assign l3  = csa(l2a[15:0], l2a[31:16], l2b[15:0]);
    assign l4  = csa(l3[15:0], l3[31:16], l2b[31:16]);
    assign p_o = l4[15:0] + l4[31:16];
endmodule

module mul_seq_32 #(
    parameter int XLEN = 32,
    parameter int NPP  = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [31:0] mag_a_q, mag_b_q;
    logic        neg_q;
    logic [63:0] acc_q;
    logic [3:0]  cnt_q;
    logic        busy_q, done_q;
    logic [31:0] result_q;

    // Operand sign handling at acceptance: magnitudes are unsigned 32-bit, so 0x8000_0000
    // negates to itself and is still the correct magnitude.
    logic        sgn_a, sgn_b;
    logic [31:0] mag_a_d, mag_b_d;

    always_comb begin
        sgn_a   = ((op_i == OP_MULH) || (op_i == OP_MULHSU)) && rs1_i[31];
        sgn_b   = (op_i == OP_MULH) && rs2_i[31];
        mag_a_d = sgn_a ? (~rs1_i + 32'd1) : rs1_i;
        mag_b_d = sgn_b ? (~rs2_i + 32'd1) : rs2_i;
    end

    // Current byte pair: i selects the byte of |A|, j the byte of |B|.
    logic [1:0]  idx_i, idx_j;
    logic [7:0]  byte_a, byte_b;
    logic [15:0] pp;
    logic [2:0]  ij_sum;
    logic [5:0]  shamt;
    logic [63:0] acc_sum_d, acc_fix_d;

    assign idx_i  = cnt_q[1:0];
    assign idx_j  = cnt_q[3:2];
    assign byte_a = mag_a_q[{idx_i, 3'b000} +: 8];
    assign byte_b = mag_b_q[{idx_j, 3'b000} +: 8];

    wallace_8 u_wallace_8 (
        .a_i (byte_a),
        .b_i (byte_b),
        .p_o (pp)
    );

    assign ij_sum    = {1'b0, idx_i} + {1'b0, idx_j};
    assign shamt     = {ij_sum, 3'b000};
    assign acc_sum_d = acc_q + ({48'd0, pp} << shamt);
    assign acc_fix_d = neg_q ? (~acc_q + 64'd1) : acc_q;

    // Counter sequencing. In the low-half-only mode a MUL visits just the pairs with i+j<=3;
    // when the increment would land on i+j>=4 the counter jumps to i=0 of the next B byte.
    logic       low_only;
    logic [3:0] cnt_inc, cnt_d;
    logic [2:0] nxt_sum;
    logic       last_pp;

`ifdef MUL_SEQ_FAST_LOW_EN
    assign low_only = (op_q == OP_MUL);
`else
    assign low_only = 1'b0;
`endif

    always_comb begin
        cnt_inc = cnt_q + 4'd1;
        nxt_sum = {1'b0, cnt_inc[1:0]} + {1'b0, cnt_inc[3:2]};
        cnt_d   = cnt_inc;
        if (low_only && nxt_sum[2]) begin
            cnt_d = {cnt_q[3:2] + 2'd1, 2'b00};
        end
        last_pp = low_only ? (cnt_q == 4'd12) : (cnt_q == 4'(NPP - 1));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            mag_a_q  <= 32'd0;
            mag_b_q  <= 32'd0;
            neg_q    <= 1'b0;
            acc_q    <= 64'd0;
            cnt_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else if (flush_i) begin
            // Abort from any state; the previous result stays visible.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_q    <= op_i;
                        mag_a_q <= mag_a_d;
                        mag_b_q <= mag_b_d;
                        neg_q   <= sgn_a ^ sgn_b;
                        acc_q   <= 64'd0;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_sum_d;
                    cnt_q <= cnt_d;
                    if (last_pp) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    acc_q    <= acc_fix_d;
                    result_q <= (op_q == OP_MUL) ? acc_fix_d[31:0] : acc_fix_d[63:32];
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    // start_i seen here is deliberately dropped; it is taken in the next IDLE cycle.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
endmodule

// File: tb/tb_mul_seq_32.sv
// Purpose : self-checking bench for mul_seq_32 using a scoreboard of expected results.
// Latency : checks done_o position relative to the accepting edge.
// Backpressure: exercises ignored starts, flush and mid-operation reset.
module tb_mul_seq_32;
    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] rs1_i = 32'd0;
    logic [31:0] rs2_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    localparam int LAT_FULL = 17;
`ifdef MUL_SEQ_FAST_LOW_EN
    localparam int LAT_MUL = 11;
`else
    localparam int LAT_MUL = 17;
`endif

    always #5 clk_i = ~clk_i;

    mul_seq_32 dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    // Reference: full 64-bit product of the sign/zero-extended operands.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_lat(input logic [1:0] op);
        return (op == 2'b00) ? LAT_MUL : LAT_FULL;
    endfunction

    // Presents a request for the accepting edge; returns at the negedge after it.
    task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        if (push) exp_q.push_back(model(op, a, b));
        @(negedge clk_i);
        start_i = 1'b0;
        rs1_i   = $urandom;
        rs2_i   = $urandom;
    endtask

    // Counts edges since acceptance until done_o; optionally pulses a junk start at edge junk_at+1.
    task automatic wait_done(input int junk_at, output int lat, output bit busy_ok, output bit got);
        lat = 0;
        busy_ok = 1'b1;
        got = 1'b0;
        while (lat < 100) begin
            if (!busy_o) busy_ok = 1'b0;
            if (done_o) begin
                got = 1'b1;
                break;
            end
            if (lat == junk_at) begin
                start_i = 1'b1;
                op_i    = 2'($urandom_range(0, 3));
                rs1_i   = $urandom;
                rs2_i   = $urandom;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            lat++;
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) @(negedge clk_i);
        vectors++;
        if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        vectors++;
        if (done_o !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done_o); end
        vectors++;
        if (result_o !== 32'd0) begin miscompares++; $display("FAIL reset_result: got %h want 0", result_o); end
        reset_i = 1'b0;
    endtask

    task automatic test_mul_basic();
        int lat; bit busy_ok, got; logic [31:0] exp;
        drive_start(2'b00, 32'd7, 32'd6, 1'b1);
        wait_done(-1, lat, busy_ok, got);
        exp = exp_q.pop_front();
        vectors++;
        if (!got || lat != LAT_MUL) begin miscompares++; $display("FAIL mul_basic_latency: got %0d (done=%b) want %0d", lat, got, LAT_MUL); end
        vectors++;
        if (!busy_ok) begin miscompares++; $display("FAIL mul_basic_busy: busy dropped, want high throughout"); end
        vectors++;
        if (result_o !== exp || result_o !== 32'h0000_002A) begin miscompares++; $display("FAIL mul_basic_result: got %h want %h", result_o, exp); end
        @(negedge clk_i);
        vectors++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin miscompares++; $display("FAIL mul_basic_pulse: done=%b busy=%b want 0 0", done_o, busy_o); end
        vectors++;
        if (result_o !== exp) begin miscompares++; $display("FAIL mul_basic_hold: got %h want %h", result_o, exp); end
    endtask

    task automatic test_signed();
        logic [1:0]  ops [6] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b11};
        logic [31:0] as  [6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        logic [31:0] bs  [6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0005};
        logic [31:0] lit [6] = '{32'h4000_0000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0000};
        int lat; bit busy_ok, got; logic [31:0] exp;
        for (int t = 0; t < 6; t++) begin
            drive_start(ops[t], as[t], bs[t], 1'b1);
            wait_done(-1, lat, busy_ok, got);
            exp = exp_q.pop_front();
            vectors++;
            if (!got || lat != exp_lat(ops[t])) begin miscompares++; $display("FAIL signed_latency[%0d]: got %0d want %0d", t, lat, exp_lat(ops[t])); end
            vectors++;
            if (result_o !== exp || result_o !== lit[t]) begin miscompares++; $display("FAIL signed_result[%0d]: got %h want %h", t, result_o, lit[t]); end
        end
    endtask

    task automatic test_busy_start();
        int lat; bit busy_ok, got; logic [31:0] exp;
        drive_start(2'b00, 32'h0001_2345, 32'h0000_6789, 1'b1);
        wait_done(2, lat, busy_ok, got);
        exp = exp_q.pop_front();
        vectors++;
        if (!got || result_o !== exp) begin miscompares++; $display("FAIL busy_start_result: got %h want %h", result_o, exp); end
    endtask

    task automatic test_flush();
        int lat; bit busy_ok, got, seen; logic [31:0] prev, exp;
        prev = result_o;
        drive_start(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        for (int e = 0; e < 5; e++) begin
            start_i = (e == 2);
            if (e == 2) begin op_i = 2'b00; rs1_i = 32'hDEAD_BEEF; rs2_i = 32'h0000_0003; end
            flush_i = (e == 4);
            @(negedge clk_i);
        end
        start_i = 1'b0;
        flush_i = 1'b0;
        vectors++;
        if (busy_o !== 1'b0) begin miscompares++; $display("FAIL flush_busy: got %b want 0", busy_o); end
        vectors++;
        if (result_o !== prev) begin miscompares++; $display("FAIL flush_result_hold: got %h want %h", result_o, prev); end
        seen = 1'b0;
        for (int e = 0; e < 25; e++) begin
            if (done_o) seen = 1'b1;
            @(negedge clk_i);
        end
        vectors++;
        if (seen) begin miscompares++; $display("FAIL flush_no_done: got done pulse want none"); end
        drive_start(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        wait_done(-1, lat, busy_ok, got);
        exp = exp_q.pop_front();
        vectors++;
        if (!got || result_o !== exp || result_o !== 32'h0B00_EA4E) begin miscompares++; $display("FAIL flush_restart: got %h want %h", result_o, exp); end
        // flush together with start in IDLE: the request must not be taken
        @(negedge clk_i);
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; rs1_i = 32'd3; rs2_i = 32'd4;
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        vectors++;
        if (busy_o !== 1'b0) begin miscompares++; $display("FAIL flush_start_idle: busy got %b want 0", busy_o); end
    endtask

    task automatic test_reset_mid();
        int lat; bit busy_ok, got, seen; logic [31:0] exp;
        drive_start(2'b01, 32'h9876_5432, 32'h0F0F_1234, 1'b0);
        for (int e = 0; e < 8; e++) begin
            reset_i = (e == 7);
            @(negedge clk_i);
        end
        vectors++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'd0) begin
            miscompares++; $display("FAIL reset_mid_outputs: busy=%b done=%b result=%h want 0 0 0", busy_o, done_o, result_o);
        end
        reset_i = 1'b0;
        seen = 1'b0;
        for (int e = 0; e < 25; e++) begin
            if (done_o) seen = 1'b1;
            @(negedge clk_i);
        end
        vectors++;
        if (seen) begin miscompares++; $display("FAIL reset_mid_no_done: got done pulse want none"); end
        drive_start(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
        wait_done(-1, lat, busy_ok, got);
        exp = exp_q.pop_front();
        vectors++;
        if (!got || result_o !== exp || result_o !== 32'hFFFF_FFFA) begin miscompares++; $display("FAIL reset_mid_after: got %h want %h", result_o, exp); end
    endtask

    task automatic test_back_to_back();
        int lat; bit busy_ok, got; logic [31:0] exp;
        drive_start(2'b10, 32'h8000_0001, 32'h7654_3210, 1'b1);
        wait_done(-1, lat, busy_ok, got);
        exp = exp_q.pop_front();
        vectors++;
        if (!got || result_o !== exp) begin miscompares++; $display("FAIL b2b_first: got %h want %h", result_o, exp); end
        // start raised in the DONE cycle and held into IDLE
        start_i = 1'b1; op_i = 2'b00; rs1_i = 32'h0000_1111; rs2_i = 32'h0000_2222;
        exp_q.push_back(model(2'b00, 32'h0000_1111, 32'h0000_2222));
        @(negedge clk_i);
        vectors++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin miscompares++; $display("FAIL b2b_done_ignored: busy=%b done=%b want 0 0", busy_o, done_o); end
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done(-1, lat, busy_ok, got);
        exp = exp_q.pop_front();
        vectors++;
        if (!got || lat != LAT_MUL) begin miscompares++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT_MUL); end
        vectors++;
        if (result_o !== exp) begin miscompares++; $display("FAIL b2b_second: got %h want %h", result_o, exp); end
    endtask

    task automatic test_random();
        int lat; bit busy_ok, got; logic [31:0] exp, a, b; logic [1:0] op;
        for (int t = 0; t < 12; t++) begin
            op = 2'($urandom_range(0, 3));
            a  = (t % 4 == 0) ? 32'h8000_0000 : $urandom;
            b  = (t % 3 == 0) ? 32'hFFFF_FFFF : $urandom;
            drive_start(op, a, b, 1'b1);
            wait_done(-1, lat, busy_ok, got);
            exp = exp_q.pop_front();
            vectors++;
            if (!got || lat != exp_lat(op) || !busy_ok) begin miscompares++; $display("FAIL random_timing[%0d]: lat %0d want %0d busy_ok %b", t, lat, exp_lat(op), busy_ok); end
            vectors++;
            if (result_o !== exp) begin miscompares++; $display("FAIL random_result[%0d] op %0d: got %h want %h", t, op, result_o, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_signed();
        test_busy_start();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
